// File: rtl/uart_tx_fifo_if.sv
// Valid/ready byte handshake between a producer and the UART transmitter FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned P_DATA_BITS = 8
);
    logic                   i_TX_VALID;
    logic [P_DATA_BITS-1:0] i_DATA_IN;
    logic                   o_TX_READY;

    modport master (output i_TX_VALID, output i_DATA_IN, input  o_TX_READY);
    modport slave  (input  i_TX_VALID, input  i_DATA_IN, output o_TX_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO; configurable data width, parity and stop bits.
// Frames are sent back-to-back with no idle gap while words are queued.
module uart_tx_fifo #(
    parameter int unsigned P_DATA_BITS  = 8,
    parameter int unsigned P_PARITY     = 0,
    parameter int unsigned P_STOP_BITS  = 1,
    parameter int unsigned P_FIFO_DEPTH = 4
) (
    input  logic                                   i_CLK,
    input  logic                                   i_RESET,
    input  logic                                   i_CLK_ENABLE,
    uart_tx_fifo_if.slave                          tx_if,
    output logic                                   o_TX,
    output logic                                   o_TX_BUSY,
    output logic [$clog2(P_FIFO_DEPTH+1)-1:0]      o_FIFO_COUNT,
    output logic                                   o_FIFO_FULL,
    output logic                                   o_FIFO_EMPTY
);

    localparam int unsigned CNT_W = $clog2(P_FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int unsigned IDX_W = $clog2(P_DATA_BITS);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(P_DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(P_STOP_BITS - 1);
    localparam logic             PAR_EN    = (P_PARITY != 0);
    localparam logic             PAR_ODD   = (P_PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic                   tx_q, tx_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [P_DATA_BITS-1:0] shift_q, shift_d;
    logic                   par_q, par_d;

    logic [P_DATA_BITS-1:0] mem_q [P_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push_c;
    logic                   pop_c;
    logic [P_DATA_BITS-1:0] head;

    assign fifo_full  = (count_q == CNT_W'(P_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign push_c     = tx_if.i_TX_VALID && !fifo_full;

    assign tx_if.o_TX_READY = !fifo_full;
    assign o_TX             = tx_q;
    assign o_TX_BUSY        = (state_q != ST_IDLE);
    assign o_FIFO_COUNT     = count_q;
    assign o_FIFO_FULL      = fifo_full;
    assign o_FIFO_EMPTY     = fifo_empty;

    // Frame sequencer: state names the bit currently on the line
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop_c   = 1'b0;
        if (i_CLK_ENABLE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) pop_c = 1'b1;
                end
                ST_START: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (idx_q != IDX_LAST) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = IDX_W'(idx_q + 1'b1);
                    end else if (PAR_EN) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_q != STOP_LAST) begin
                        stop_d = 1'(stop_q + 1'b1);
                    end else if (!fifo_empty) begin
                        pop_c = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
            // Loading the head word and driving the start bit happen together
            if (pop_c) begin
                tx_d    = 1'b0;
                shift_d = head;
                par_d   = (^head) ^ PAR_ODD;
                state_d = ST_START;
            end
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        if (pop_c)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        unique case ({push_c, pop_c})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset; occupancy alone defines validity
    always_ff @(posedge i_CLK) begin
        if (push_c && !i_RESET) mem_q[wr_ptr_q] <= tx_if.i_DATA_IN;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E1, 7O1 and 8N2 instances share clock and tick.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_o;
    logic tick;

    int n_vec  = 0;
    int n_miss = 0;

    uart_tx_fifo_if #(.P_DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.P_DATA_BITS(7)) if_b ();
    uart_tx_fifo_if #(.P_DATA_BITS(7)) if_c ();
    uart_tx_fifo_if #(.P_DATA_BITS(8)) if_d ();

    logic       tx_a, busy_a, full_a, empty_a;
    logic [2:0] cnt_a;
    logic       tx_b, busy_b, full_b, empty_b;
    logic [2:0] cnt_b;
    logic       tx_c, busy_c, full_c, empty_c;
    logic [2:0] cnt_c;
    logic       tx_d, busy_d, full_d, empty_d;
    logic [2:0] cnt_d;

    uart_tx_fifo #(.P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)) u_a (
        .i_CLK(clk), .i_RESET(rst_a), .i_CLK_ENABLE(tick), .tx_if(if_a.slave),
        .o_TX(tx_a), .o_TX_BUSY(busy_a), .o_FIFO_COUNT(cnt_a),
        .o_FIFO_FULL(full_a), .o_FIFO_EMPTY(empty_a));

    uart_tx_fifo #(.P_DATA_BITS(7), .P_PARITY(2), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)) u_b (
        .i_CLK(clk), .i_RESET(rst_o), .i_CLK_ENABLE(tick), .tx_if(if_b.slave),
        .o_TX(tx_b), .o_TX_BUSY(busy_b), .o_FIFO_COUNT(cnt_b),
        .o_FIFO_FULL(full_b), .o_FIFO_EMPTY(empty_b));

    uart_tx_fifo #(.P_DATA_BITS(7), .P_PARITY(1), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)) u_c (
        .i_CLK(clk), .i_RESET(rst_o), .i_CLK_ENABLE(tick), .tx_if(if_c.slave),
        .o_TX(tx_c), .o_TX_BUSY(busy_c), .o_FIFO_COUNT(cnt_c),
        .o_FIFO_FULL(full_c), .o_FIFO_EMPTY(empty_c));

    uart_tx_fifo #(.P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(2), .P_FIFO_DEPTH(4)) u_d (
        .i_CLK(clk), .i_RESET(rst_o), .i_CLK_ENABLE(tick), .tx_if(if_d.slave),
        .o_TX(tx_d), .o_TX_BUSY(busy_d), .o_FIFO_COUNT(cnt_d),
        .o_FIFO_FULL(full_d), .o_FIFO_EMPTY(empty_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given tick level; returns 1 time unit after the edge
    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  fa;
        logic [9:0]  fe;
        logic [9:0]  fo;
        logic [10:0] fd;
        logic [7:0]  words [3];
        int          busy_n;
        int          busy_nb;
        int          busy_nc;
        int          bad;

        tick = 1'b0;
        rst_a = 1'b1;
        rst_o = 1'b1;
        if_a.i_TX_VALID = 1'b0; if_a.i_DATA_IN = '0;
        if_b.i_TX_VALID = 1'b0; if_b.i_DATA_IN = '0;
        if_c.i_TX_VALID = 1'b0; if_c.i_DATA_IN = '0;
        if_d.i_TX_VALID = 1'b0; if_d.i_DATA_IN = '0;
        repeat (3) step(1'b0);
        rst_a = 1'b0;
        rst_o = 1'b0;
        step(1'b0);

        chk("rst_tx",    32'(tx_a), 1);
        chk("rst_busy",  32'(busy_a), 0);
        chk("rst_cnt",   32'(cnt_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full",  32'(full_a), 0);
        chk("rst_ready", 32'(if_a.o_TX_READY), 1);

        // 8N1, 0xA5, tick every 4 clocks
        if_a.i_TX_VALID = 1'b1;
        if_a.i_DATA_IN  = 8'hA5;
        step(1'b0);
        if_a.i_TX_VALID = 1'b0;
        chk("a5_cnt", 32'(cnt_a), 1);
        fa = {1'b1, 8'hA5, 1'b0};
        busy_n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                step(k == 0);
                chk("a5_bit", 32'(tx_a), 32'(fa[b]));
                if (b == 0 && k == 0) chk("a5_empty", 32'(empty_a), 1);
                if (busy_a) busy_n++;
            end
        end
        step(1'b1);
        chk("a5_idle_busy", 32'(busy_a), 0);
        chk("a5_idle_tx",   32'(tx_a), 1);
        chk("a5_busy_len",  32'(busy_n), 40);

        // Fill with no ticks: 6 offered, 4 accepted
        for (int i = 0; i < 6; i++) begin
            if_a.i_TX_VALID = 1'b1;
            if_a.i_DATA_IN  = 8'(8'h10 + i);
            step(1'b0);
            chk("fill_cnt", 32'(cnt_a), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("fill_full",  32'(full_a), 1);
        chk("fill_ready", 32'(if_a.o_TX_READY), 0);
        chk("fill_empty", 32'(empty_a), 0);

        // Push held on the pop tick of a full FIFO is rejected
        if_a.i_DATA_IN = 8'hEE;
        step(1'b1);
        if_a.i_TX_VALID = 1'b0;
        chk("popfull_cnt",   32'(cnt_a), 3);
        chk("popfull_ready", 32'(if_a.o_TX_READY), 1);
        chk("popfull_start", 32'(tx_a), 0);

        fa = {1'b1, 8'h10, 1'b0};
        for (int b = 1; b < 10; b++) begin
            step(1'b1);
            chk("f10_bit", 32'(tx_a), 32'(fa[b]));
        end
        step(1'b1);
        chk("f11_start", 32'(tx_a), 0);
        chk("f11_busy",  32'(busy_a), 1);
        chk("f11_cnt",   32'(cnt_a), 2);
        fa = {1'b1, 8'h11, 1'b0};
        for (int b = 1; b < 5; b++) begin
            step(1'b1);
            chk("f11_bit", 32'(tx_a), 32'(fa[b]));
        end

        // Reset during data bit 3 with two words still queued
        rst_a = 1'b1;
        step(1'b1);
        chk("mrst_tx",    32'(tx_a), 1);
        chk("mrst_busy",  32'(busy_a), 0);
        chk("mrst_cnt",   32'(cnt_a), 0);
        chk("mrst_empty", 32'(empty_a), 1);
        rst_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        chk("mrst_quiet", 32'(bad), 0);
        chk("mrst_ready", 32'(if_a.o_TX_READY), 1);

        // 7E1 and 7O1 with 0x55: four ones, so even parity 0, odd parity 1
        if_b.i_TX_VALID = 1'b1; if_b.i_DATA_IN = 7'h55;
        if_c.i_TX_VALID = 1'b1; if_c.i_DATA_IN = 7'h55;
        step(1'b0);
        if_b.i_TX_VALID = 1'b0;
        if_c.i_TX_VALID = 1'b0;
        fe = {1'b1, 1'b0, 7'h55, 1'b0};
        fo = {1'b1, 1'b1, 7'h55, 1'b0};
        busy_nb = 0;
        busy_nc = 0;
        for (int b = 0; b < 10; b++) begin
            step(1'b1);
            chk("even_bit", 32'(tx_b), 32'(fe[b]));
            chk("odd_bit",  32'(tx_c), 32'(fo[b]));
            if (busy_b) busy_nb++;
            if (busy_c) busy_nc++;
        end
        step(1'b1);
        chk("even_len",  32'(busy_nb), 10);
        chk("odd_len",   32'(busy_nc), 10);
        chk("even_idle", 32'(busy_b), 0);
        chk("odd_idle",  32'(busy_c), 0);

        // 8N2: three words queued, frames back-to-back
        words[0] = 8'h3C;
        words[1] = 8'hC3;
        words[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            if_d.i_TX_VALID = 1'b1;
            if_d.i_DATA_IN  = words[i];
            step(1'b0);
        end
        if_d.i_TX_VALID = 1'b0;
        chk("n2_cnt", 32'(cnt_d), 3);
        for (int w = 0; w < 3; w++) begin
            fd = {2'b11, words[w], 1'b0};
            for (int b = 0; b < 11; b++) begin
                step(1'b1);
                chk("n2_bit",  32'(tx_d), 32'(fd[b]));
                chk("n2_busy", 32'(busy_d), 1);
            end
        end
        step(1'b1);
        chk("n2_idle_busy", 32'(busy_d), 0);
        chk("n2_idle_tx",   32'(tx_d), 1);
        chk("n2_empty",     32'(empty_d), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO and configurable frame format: data width, parity and stop-bit count. It sits between a valid/ready byte producer and the serial TX pin. Baud timing comes from an external one-bit-period tick, as for the existing transmitter. Unlike that block, it accepts words back-to-back and queues them, and it emits frames with no idle gap while data is queued.

## Interface
- P_DATA_BITS, 8, data bits per frame; legal range 5..9.
- P_PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- P_STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- P_FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.
- i_CLK  in  1  single clock; all logic on rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_CLK_ENABLE  in  1  baud tick; one i_CLK-wide pulse per bit period; may be tied high.
- i_TX_VALID  in  1  producer has a word on i_DATA_IN.
- i_DATA_IN  in  P_DATA_BITS  word to transmit; bit 0 is sent first.
- o_TX_READY  out  1  FIFO can accept a word; equals !o_FIFO_FULL.
- o_TX  out  1  serial line; idles high.
- o_TX_BUSY  out  1  high while a frame is on the line (state != IDLE).
- o_FIFO_COUNT  out  $clog2(P_FIFO_DEPTH+1)  words currently queued.
- o_FIFO_FULL  out  1  o_FIFO_COUNT == P_FIFO_DEPTH.
- o_FIFO_EMPTY  out  1  o_FIFO_COUNT == 0.

## Operation
- Push: a word is written when i_TX_VALID && o_TX_READY at a rising edge. Pushes are ignored while i_RESET is high. When the FIFO is full, ready is low and a push is not accepted even if a pop occurs in the same cycle.
- Pop: the head word is loaded into the shift register at the tick that drives the start bit.
- Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo P_FIFO_DEPTH.
- FSM states, each named for the bit currently driven on o_TX: IDLE, START, DATA, PARITY, STOP. State and o_TX update only on edges where i_CLK_ENABLE = 1. With no tick, everything holds except FIFO pushes.
- IDLE: o_TX = 1. On a tick with the FIFO non-empty: pop, drive 0, go to START.
- START: on tick, drive data bit 0; bit index = 0; go to DATA.
- DATA: on tick, while index < P_DATA_BITS-1, drive the next bit LSB-first and increment the index. After the last bit:
  - if P_PARITY != 0, drive the parity bit and go to PARITY;
  - otherwise drive 1 and go to STOP with stop count = 0.
- Parity bit: even = XOR of the data bits; odd = inverted XOR of the data bits.
- PARITY: on tick, drive 1; go to STOP with stop count = 0.
- STOP: on tick, if stop count < P_STOP_BITS-1, hold 1 and increment the count. Otherwise:
  - if the FIFO is non-empty, pop, drive 0 and go to START (no idle gap);
  - else go to IDLE with o_TX = 1.
- Frame length = 1 + P_DATA_BITS + (P_PARITY != 0) + P_STOP_BITS bit periods.
- Reset: state = IDLE, o_TX = 1, o_TX_BUSY = 0, FIFO flushed (count 0, empty 1, full 0, ready 1 after reset deasserts). Bit index and stop count go to 0.
- Reset mid-frame aborts the frame. o_TX is 1 from the edge where i_RESET is sampled high. Queued words are discarded.

## Timing
- All outputs are registered, or decoded only from registered count and state. There are no combinational input-to-output paths.
- o_FIFO_COUNT, full, empty and ready update on the edge following a push or pop.
- Minimum latency: a word pushed at edge t into an empty, IDLE block produces the start bit at the first tick edge at or after t+1.
- Each bit is held from one tick edge to the next. With i_CLK_ENABLE tied high, each bit lasts 1 clock.
- o_TX_BUSY rises at the same edge as the start bit and falls at the edge that returns the FSM to IDLE. It stays high across back-to-back frames.

## Test plan
- 8N1, tick every 4 clocks, push 0xA5 -> o_TX sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clocks; o_TX_BUSY high for 40 clocks; FIFO empty after the start bit.
- P_DATA_BITS=7, P_PARITY=2, push 0x55 -> parity bit 0. Same with P_PARITY=1 -> parity bit 1. Frame is 10 bit periods.
- P_STOP_BITS=2, push 3 words back-to-back -> 3 contiguous 11-bit frames, two stop bits each, no idle gap; o_TX_BUSY continuously high.
- P_FIFO_DEPTH=4, no ticks, i_TX_VALID held for 6 cycles -> 4 accepted, count 4, full 1, ready 0; later words are not stored.
- Full FIFO with push asserted on the pop tick -> push rejected, count becomes 3, ready rises the following cycle.
- i_RESET pulsed during data bit 3 with 2 words queued -> o_TX = 1 at the next edge, busy 0, count 0; no further frames sent.
